// File: rtl/carregador_matrizes.sv
// Serial loader for the 5x5 matrix multiplier: receives A then B row-major over a
// valid/ready byte stream and presents them as zero-filled packed buses until acknowledged.
module carregador_matrizes #(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        matrix_size,
  input  logic [ELEM_W-1:0]                 data_in,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] A,
  output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] B,
  output logic [1:0]                        size_out,
  output logic                              matrices_valid,
  input  logic                              out_ack,
  output logic                              busy
);

  localparam int ROW_W = DIM_MAX * ELEM_W;
  localparam int BUS_W = DIM_MAX * ROW_W;
  localparam int POS_W = $clog2(BUS_W);
  localparam int IDX_W = $clog2(DIM_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [BUS_W-1:0]   a_q, b_q;
  logic [1:0]         size_q;
  logic [IDX_W-1:0]   row, col, last;
  logic [POS_W-1:0]   pos;
  logic               start_ok, xfer, last_xfer;

  // Handshake: a byte moves on a rising edge where data_valid && data_ready;
  // data_ready depends only on the registered state, never on data_valid.
  assign busy           = (state == LOAD_A) || (state == LOAD_B);
  assign data_ready     = busy;
  assign matrices_valid = (state == DONE);
  assign A              = a_q;
  assign B              = b_q;
  assign size_out       = size_q;

  // Size code 0..3 means N = 2..5, so the last row/col index is code + 1.
  assign last      = IDX_W'(size_q) + IDX_W'(1);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign xfer      = data_valid && busy;
  assign last_xfer = xfer && (row == last) && (col == last);
  assign pos       = POS_W'(row) * POS_W'(ROW_W) + POS_W'(col) * POS_W'(ELEM_W);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  if (last_xfer) state_next = LOAD_B;
      LOAD_B:  if (last_xfer) state_next = DONE;
      DONE: begin
        if (start)        state_next = LOAD_A;
        else if (out_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      size_q <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        a_q    <= '0;
        b_q    <= '0;
        size_q <= matrix_size;
        row    <= '0;
        col    <= '0;
      end else if (xfer) begin
        if (state == LOAD_A) a_q[pos +: ELEM_W] <= data_in;
        else                 b_q[pos +: ELEM_W] <= data_in;
        // Wrapping both indices on the final element readies them for matrix B.
        if (col == last) begin
          col <= '0;
          row <= (row == last) ? '0 : row + IDX_W'(1);
        end else begin
          col <= col + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_carregador_matrizes.sv
// Randomized bench for carregador_matrizes; expected buses are rebuilt from the
// list of accepted bytes using row-major placement and zero fill.
module tb_carregador_matrizes;

  localparam int BUS_W = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       matrix_size;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [BUS_W-1:0] a_bus;
  logic [BUS_W-1:0] b_bus;
  logic [1:0]       size_out;
  logic             matrices_valid;
  logic             out_ack;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: mode 0=idle, 1=loading, 2=done; exp_q holds bytes accepted this load.
  int         md       = 0;
  int         n_cur    = 2;
  logic [1:0] exp_size = 2'd0;
  logic [7:0] exp_q[$];
  logic [7:0] s[$];

  carregador_matrizes dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .matrix_size    (matrix_size),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .A              (a_bus),
    .B              (b_bus),
    .size_out       (size_out),
    .matrices_valid (matrices_valid),
    .out_ack        (out_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Matrix sel (0=A, 1=B) occupies bytes sel*N*N .. sel*N*N+N*N-1 of the stream.
  function automatic logic [BUS_W-1:0] model_bus(input int sel);
    logic [BUS_W-1:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < n_cur * n_cur; k++) begin
      idx = sel * n_cur * n_cur + k;
      if (idx < exp_q.size()) r[(k / n_cur) * 40 + (k % n_cur) * 8 +: 8] = exp_q[idx];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy"},  BUS_W'(busy),           BUS_W'(md == 1));
    check({tag, "_ready"}, BUS_W'(data_ready),     BUS_W'(md == 1));
    check({tag, "_valid"}, BUS_W'(matrices_valid), BUS_W'(md == 2));
    check({tag, "_size"},  BUS_W'(size_out),       BUS_W'(exp_size));
    check({tag, "_a"},     a_bus,                  model_bus(0));
    check({tag, "_b"},     b_bus,                  model_bus(1));
  endtask

  task automatic do_start(input logic [1:0] code, input logic ack);
    start = 1'b1;
    matrix_size = code;
    out_ack = ack;
    tick();
    start = 1'b0;
    out_ack = 1'b0;
    if (md != 1) begin
      md = 1;
      n_cur = int'(code) + 2;
      exp_size = code;
      exp_q.delete();
    end
    check_all("start");
  endtask

  task automatic send(input logic [7:0] b, input int gaps);
    repeat (gaps) begin
      data_valid = 1'b0;
      out_ack = (md == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in = 8'($urandom);
      tick();
      out_ack = 1'b0;
    end
    data_valid = 1'b1;
    data_in = b;
    tick();
    data_valid = 1'b0;
    if (md == 1) begin
      exp_q.push_back(b);
      if (exp_q.size() == 2 * n_cur * n_cur) md = 2;
    end
    check_all("xfer");
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    if (md == 2) md = 0;
    check_all("ack");
  endtask

  task automatic random_load(input logic [1:0] code, input int max_gap);
    int n;
    n = int'(code) + 2;
    do_start(code, 1'b0);
    for (int i = 0; i < 2 * n * n; i++) send(8'($urandom), $urandom_range(0, max_gap));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    matrix_size = 2'd0;
    data_in = 8'd0;
    data_valid = 1'b0;
    out_ack = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_all("idle");

    // 2x2 directed
    do_start(2'b00, 1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    check("2x2_a_lit", BUS_W'(a_bus), BUS_W'(56'h04030000000201));
    check("2x2_b_lit", BUS_W'(b_bus), BUS_W'(56'h08070000000605));
    do_ack();

    // 5x5 with negatives, B = identity
    do_start(2'b11, 1'b0);
    for (int k = 0; k < 25; k++) send(8'(k - 12), 0);
    for (int k = 0; k < 25; k++) send((k % 6 == 0) ? 8'd1 : 8'd0, 0);
    check("5x5_a_first", BUS_W'(a_bus[7:0]),     BUS_W'(8'hF4));
    check("5x5_a_last",  BUS_W'(a_bus[199:192]), BUS_W'(8'h0C));
    check("5x5_b_last",  BUS_W'(b_bus[199:192]), BUS_W'(8'h01));
    check("5x5_b_01",    BUS_W'(b_bus[15:8]),    BUS_W'(8'h00));

    // 3x3 with valid pattern 1,0,0,1,0,0...
    do_start(2'b01, 1'b0);
    s.delete();
    for (int i = 0; i < 18; i++) begin
      s.push_back(8'($urandom));
      send(s[i], (i == 0) ? 0 : 2);
    end
    check("3x3_a_r2c0", BUS_W'(a_bus[87:80]),   BUS_W'(s[6]));
    check("3x3_a_hi",   BUS_W'(a_bus[199:120]), BUS_W'(0));

    // start during LOAD_A is ignored, even with a different size code
    do_start(2'b01, 1'b0);
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    do_start(2'b11, 1'b0);
    for (int i = 0; i < 16; i++) send(8'($urandom), $urandom_range(0, 1));

    // start and out_ack together in DONE: restart wins
    do_start(2'b10, 1'b1);
    for (int i = 0; i < 32; i++) send(8'($urandom), $urandom_range(0, 2));
    do_ack();
    // data_valid and out_ack in IDLE do nothing
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    do_ack();

    // asynchronous reset mid LOAD_B, then a clean 2x2 load
    do_start(2'b00, 1'b0);
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    md = 0;
    exp_size = 2'd0;
    exp_q.delete();
    check_all("rst_async");
    #1;
    rst = 1'b0;
    random_load(2'b00, 1);
    do_ack();

    // randomized loads, finished either by ack or by restart
    for (int it = 0; it < 5; it++) begin
      random_load(2'($urandom_range(0, 3)), 3);
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
